// File: rtl/debounce_pkg.sv
// ============================================================================
// Module : debounce_pkg
// Brief  : Shared FSM state encoding and default stability length for the
//          button debouncer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_e;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  // Wide enough to hold STABLE_CYCLES-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// Module : debounce_chan
// Brief  : One debounced channel: 2-flop synchroniser, stability counter and
//          four-state FSM. Rise/fall pulse flops exist only when
//          DEBOUNCE_EDGE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
`ifdef DEBOUNCE_EDGE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic db_o
);

  localparam int unsigned CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             db_q;
`ifdef DEBOUNCE_EDGE_EN
  logic             rise_q;
  logic             fall_q;
`endif

  // s1_q may go metastable; only s2_q feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
`ifdef DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        S_LOW: begin
          if (s2_q) begin
            state_q <= S_RISE_WAIT;
            cnt_q   <= c_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_RISE_WAIT: begin
          if (!s2_q) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == c_LAST) begin
            state_q <= S_HIGH;
            db_q    <= 1'b1;
            cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_EN
            rise_q  <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q + c_ONE;
          end
        end
        S_HIGH: begin
          if (!s2_q) begin
            state_q <= S_FALL_WAIT;
            cnt_q   <= c_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_FALL_WAIT: begin
          if (s2_q) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == c_LAST) begin
            state_q <= S_LOW;
            db_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_EN
            fall_q  <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q + c_ONE;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign db_o = db_q;
`ifdef DEBOUNCE_EDGE_EN
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module : button_debouncer
// Brief  : N independent synchronised/debounced inputs. Define
//          DEBOUNCE_EDGE_EN to add per-channel rise_p/fall_p pulse outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N             = 2,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_in,
`ifdef DEBOUNCE_EDGE_EN
  output logic [N-1:0] rise_p,
  output logic [N-1:0] fall_p,
`endif
  output logic [N-1:0] db_out
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_in[g]),
`ifdef DEBOUNCE_EDGE_EN
      .rise_o (rise_p[g]),
      .fall_o (fall_p[g]),
`endif
      .db_o   (db_out[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module : tb_button_debouncer
// Brief  : Directed + random bench for button_debouncer with a run-length
//          reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  localparam int unsigned c_N      = 2;
  localparam int unsigned c_STABLE = 4;

  logic           clk;
  logic           rst_n;
  logic [c_N-1:0] raw_in;
  logic [c_N-1:0] db_out;
`ifdef DEBOUNCE_EDGE_EN
  logic [c_N-1:0] rise_p;
  logic [c_N-1:0] fall_p;
`endif

  button_debouncer #(
    .N             (c_N),
    .STABLE_CYCLES (c_STABLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (raw_in),
`ifdef DEBOUNCE_EDGE_EN
    .rise_p (rise_p),
    .fall_p (fall_p),
`endif
    .db_out (db_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a pin value reaches the debounce decision two edges after it is
  // sampled; the output flips once the delayed input has disagreed with it
  // for STABLE consecutive edges.
  logic [c_N-1:0] dly_q[$];
  int             run[c_N];
  logic [c_N-1:0] m_db;
  logic [c_N-1:0] m_rise;
  logic [c_N-1:0] m_fall;

  task automatic model_reset();
    dly_q = {};
    dly_q.push_back('0);
    dly_q.push_back('0);
    for (int c = 0; c < c_N; c++) run[c] = 0;
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic [c_N-1:0] v);
    logic [c_N-1:0] s;
    s = dly_q.pop_front();
    dly_q.push_back(v);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < c_N; c++) begin
      if (s[c] == m_db[c]) begin
        run[c] = 0;
      end else begin
        run[c] = run[c] + 1;
        if (run[c] == c_STABLE) begin
          m_db[c] = s[c];
          if (s[c]) m_rise[c] = 1'b1;
          else      m_fall[c] = 1'b1;
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [c_N-1:0] obs, input logic [c_N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".db"}, db_out, m_db);
`ifdef DEBOUNCE_EDGE_EN
    chk({tag, ".rise"}, rise_p, m_rise);
    chk({tag, ".fall"}, fall_p, m_fall);
    chk({tag, ".both"}, rise_p & fall_p, '0);
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".db"}, db_out, '0);
`ifdef DEBOUNCE_EDGE_EN
    chk({tag, ".rise"}, rise_p, '0);
    chk({tag, ".fall"}, fall_p, '0);
`endif
  endtask

  // Drive between edges, advance one edge, then sample 1 ns later.
  task automatic step(input logic [c_N-1:0] v, input string tag);
    raw_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [c_N-1:0] r;

    // 1. reset with inputs high
    rst_n  = 1'b0;
    raw_in = 2'b11;
    model_reset();
    #1;
    check_idle("reset_now");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("reset_hold");
    end
    rst_n = 1'b1;
    repeat (8) step(2'b00, "settle");

    // 2. clean press on channel 0: first sample at edge 1, output at edge 6
    for (int i = 1; i <= 8; i++) begin
      step(2'b01, "press");
      chk("press.db_fixed", db_out, {1'b0, (i >= 6)});
`ifdef DEBOUNCE_EDGE_EN
      chk("press.rise_fixed", rise_p, {1'b0, (i == 6)});
`endif
    end
    repeat (8) step(2'b00, "release0");

    // 3. two-cycle glitch is rejected
    repeat (2) step(2'b01, "glitch_hi");
    for (int i = 0; i < 8; i++) begin
      step(2'b00, "glitch_lo");
      chk("glitch.db_fixed", db_out, 2'b00);
    end

    // 4. bounce on channel 1; final 0->1 sampled at step 5, output at step 10
    for (int j = 1; j <= 13; j++) begin
      r = (j == 2 || j == 4) ? 2'b00 : 2'b10;
      step(r, "bounce");
      chk("bounce.db_fixed", db_out, {(j >= 10), 1'b0});
`ifdef DEBOUNCE_EDGE_EN
      chk("bounce.rise_fixed", rise_p, {(j == 10), 1'b0});
`endif
    end
    repeat (8) step(2'b00, "release1");

    // 5. simultaneous press and release
    for (int j = 1; j <= 8; j++) begin
      step(2'b11, "simul_press");
      chk("simul_press.db_fixed", db_out, (j >= 6) ? 2'b11 : 2'b00);
`ifdef DEBOUNCE_EDGE_EN
      chk("simul_press.rise_fixed", rise_p, (j == 6) ? 2'b11 : 2'b00);
`endif
    end
    for (int j = 1; j <= 8; j++) begin
      step(2'b00, "simul_rel");
      chk("simul_rel.db_fixed", db_out, (j >= 6) ? 2'b00 : 2'b11);
`ifdef DEBOUNCE_EDGE_EN
      chk("simul_rel.fall_fixed", fall_p, (j == 6) ? 2'b11 : 2'b00);
`endif
    end

    // 6. reset mid-count discards progress
    repeat (3) step(2'b01, "midcnt");
    rst_n = 1'b0;
    #1;
    check_idle("midrst_now");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_idle("midrst_hold");
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step(2'b01, "after_rst");
      chk("after_rst.db_fixed", db_out, {1'b0, (j >= 6)});
    end

    // random toggling: short glitches and long holds on both channels
    r = raw_in;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < c_N; c++) begin
        if ($urandom_range(0, 3) == 0) r[c] = ~r[c];
      end
      step(r, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
